// File: rtl/rgb_to_yuv_conversion_pkg.sv
// RGB to YUV conversion: shared types, coefficients and helpers.
// Holds the FSM state enum, the nine matrix coefficients and offsets.
package rgb2yuv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    CALC,
    WRITE,
    DONE
  } state_t;

  localparam logic signed [17:0] C_YR = 18'sd66;
  localparam logic signed [17:0] C_YG = 18'sd129;
  localparam logic signed [17:0] C_YB = 18'sd25;
  localparam logic signed [17:0] C_UR = -18'sd38;
  localparam logic signed [17:0] C_UG = -18'sd74;
  localparam logic signed [17:0] C_UB = 18'sd112;
  localparam logic signed [17:0] C_VR = 18'sd112;
  localparam logic signed [17:0] C_VG = -18'sd94;
  localparam logic signed [17:0] C_VB = -18'sd18;

  localparam logic signed [17:0] RND   = 18'sd128;
  localparam logic signed [17:0] Y_OFF = 18'sd16;
  localparam logic signed [17:0] C_OFF = 18'sd128;

  localparam int CYC_PER_GRP = 12;
  localparam int RD_PER_GRP  = 6;

  function automatic logic [7:0] clip8(
    input logic signed [17:0] x
  );
    if (x < 18'sd0) return 8'd0;
    if (x > 18'sd255) return 8'd255;
    return x[7:0];
  endfunction

  // Rounded mean of two bytes; 9-bit sum keeps the carry.
  function automatic logic [7:0] avg8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/rgb_to_yuv_pixel.sv
// Combinational single-pixel RGB to Y/U/V with clip to 0..255.
// Ports: r, g, b in (8b each); y, u, v out (8b each).
module rgb_to_yuv_pixel
  import rgb2yuv_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic [7:0] u,
  output logic [7:0] v
);

  logic signed [17:0] rs;
  logic signed [17:0] gs;
  logic signed [17:0] bs;
  logic signed [17:0] ya;
  logic signed [17:0] ua;
  logic signed [17:0] va;

  // >>> on signed sums floors negative chroma values.
  always_comb begin
    rs = $signed({10'd0, r});
    gs = $signed({10'd0, g});
    bs = $signed({10'd0, b});
    ya = ((C_YR * rs + C_YG * gs
         + C_YB * bs + RND) >>> 8)
         + Y_OFF;
    ua = ((C_UR * rs + C_UG * gs
         + C_UB * bs + RND) >>> 8)
         + C_OFF;
    va = ((C_VR * rs + C_VG * gs
         + C_VB * bs + RND) >>> 8)
         + C_OFF;
    y  = clip8(ya);
    u  = clip8(ua);
    v  = clip8(va);
  end

endmodule

// File: rtl/rgb_to_yuv_conversion.sv
// SRAM-to-SRAM RGB to planar YUV converter, 4 pixels per group.
// Ports: clk, reset (async, active-low), start, done,
//   raddr/rdata (1-cycle read latency), waddr/wdata/wr_enable.
// Macro RGB2YUV_AVG_EN: chroma from pair average, else even pixel.
module rgb_to_yuv_conversion
  import rgb2yuv_pkg::*;
#(
  parameter int ADDR_RGB = 115200,
  parameter int ADDR_YUV = 0,
  parameter int W        = 320,
  parameter int H        = 240,
  parameter int DW       = 16,
  parameter int AW       = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int N_GRP = W * H / 4;

  localparam logic [AW-1:0] RGB_BASE =
    AW'(ADDR_RGB);
  localparam logic [AW-1:0] Y_BASE =
    AW'(ADDR_YUV);
  localparam logic [AW-1:0] U_BASE =
    AW'(ADDR_YUV + W * H / 2);
  localparam logic [AW-1:0] V_BASE =
    AW'(ADDR_YUV + 3 * W * H / 4);
  localparam logic [AW-1:0] GRP_LAST =
    AW'(N_GRP - 1);

  // Reads, then DRAIN and CALC, leave the write slots.
  localparam logic [2:0] RD_LAST =
    3'(RD_PER_GRP - 1);
  localparam logic [2:0] WR_LAST =
    3'(CYC_PER_GRP - RD_PER_GRP - 3);

  state_t        state;
  logic [2:0]    cnt;
  logic [AW-1:0] grp;
  logic [DW-1:0] cap [6];
  logic [15:0]   y23_q;
  logic [15:0]   u_q;
  logic [15:0]   v_q;

  logic [7:0] pr [4];
  logic [7:0] pg [4];
  logic [7:0] pb [4];
  logic [7:0] cr [2];
  logic [7:0] cg [2];
  logic [7:0] cb [2];
  logic [7:0] y_pix [4];
  logic [7:0] u_pix [2];
  logic [7:0] v_pix [2];
  logic [7:0] unused_u [4];
  logic [7:0] unused_v [4];
  logic [7:0] unused_y [2];

  // Word k of a pixel pair: {R0,G0} {B0,R1} {G1,B1}.
  always_comb begin
    pr[0] = cap[0][15:8];
    pg[0] = cap[0][7:0];
    pb[0] = cap[1][15:8];
    pr[1] = cap[1][7:0];
    pg[1] = cap[2][15:8];
    pb[1] = cap[2][7:0];
    pr[2] = cap[3][15:8];
    pg[2] = cap[3][7:0];
    pb[2] = cap[4][15:8];
    pr[3] = cap[4][7:0];
    pg[3] = cap[5][15:8];
    pb[3] = cap[5][7:0];
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
`ifdef RGB2YUV_AVG_EN
      cr[p] = avg8(pr[2*p], pr[2*p+1]);
      cg[p] = avg8(pg[2*p], pg[2*p+1]);
      cb[p] = avg8(pb[2*p], pb[2*p+1]);
`else
      cr[p] = pr[2*p];
      cg[p] = pg[2*p];
      cb[p] = pb[2*p];
`endif
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pair
    rgb_to_yuv_pixel u_luma_even (
      .r (pr[2*p]),
      .g (pg[2*p]),
      .b (pb[2*p]),
      .y (y_pix[2*p]),
      .u (unused_u[2*p]),
      .v (unused_v[2*p])
    );
    rgb_to_yuv_pixel u_luma_odd (
      .r (pr[2*p+1]),
      .g (pg[2*p+1]),
      .b (pb[2*p+1]),
      .y (y_pix[2*p+1]),
      .u (unused_u[2*p+1]),
      .v (unused_v[2*p+1])
    );
    rgb_to_yuv_pixel u_chroma (
      .r (cr[p]),
      .g (cg[p]),
      .b (cb[p]),
      .y (unused_y[p]),
      .u (u_pix[p]),
      .v (v_pix[p])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      grp       <= '0;
      raddr     <= '0;
      waddr     <= '0;
      wdata     <= '0;
      wr_enable <= 1'b0;
      done      <= 1'b0;
      y23_q     <= '0;
      u_q       <= '0;
      v_q       <= '0;
      for (int i = 0; i < 6; i++)
        cap[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            raddr <= RGB_BASE;
            cnt   <= 3'd0;
            grp   <= '0;
          end
        end
        READ: begin
          // rdata lags raddr by one cycle.
          if (cnt != 3'd0) begin
            for (int i = 0; i < 5; i++)
              cap[i] <= cap[i+1];
            cap[5] <= rdata;
          end
          if (cnt == RD_LAST) begin
            state <= DRAIN;
          end else begin
            cnt   <= cnt + 3'd1;
            raddr <= raddr + AW'(1);
          end
        end
        DRAIN: begin
          for (int i = 0; i < 5; i++)
            cap[i] <= cap[i+1];
          cap[5] <= rdata;
          state  <= CALC;
        end
        CALC: begin
          y23_q     <= {y_pix[2], y_pix[3]};
          u_q       <= {u_pix[0], u_pix[1]};
          v_q       <= {v_pix[0], v_pix[1]};
          waddr     <= Y_BASE + (grp << 1);
          wdata     <= DW'({y_pix[0], y_pix[1]});
          wr_enable <= 1'b1;
          cnt       <= 3'd0;
          state     <= WRITE;
        end
        WRITE: begin
          cnt <= cnt + 3'd1;
          unique case (1'b1)
            (cnt == 3'd0): begin
              waddr <= waddr + AW'(1);
              wdata <= DW'(y23_q);
            end
            (cnt == 3'd1): begin
              waddr <= U_BASE + grp;
              wdata <= DW'(u_q);
            end
            (cnt == 3'd2): begin
              waddr <= V_BASE + grp;
              wdata <= DW'(v_q);
            end
            default: begin
              wr_enable <= 1'b0;
              cnt       <= 3'd0;
              if (grp == GRP_LAST) begin
                grp   <= '0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                grp   <= grp + AW'(1);
                raddr <= raddr + AW'(1);
                state <= READ;
              end
            end
          endcase
          if (cnt > WR_LAST)
            wr_enable <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv_conversion.sv
// Self-checking bench for rgb_to_yuv_conversion on an 8x2 image.
// Scoreboard of expected SRAM writes, plus done timing checks.
module tb_rgb_to_yuv_conversion;

  localparam int W     = 8;
  localparam int H     = 2;
  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int A_RGB = 64;
  localparam int A_YUV = 0;
  localparam int NG    = W * H / 4;
  localparam int NP    = W * H;
  localparam int U0    = A_YUV + W * H / 2;
  localparam int V0    = A_YUV + 3 * W * H / 4;
  localparam int RUN   = NG * 12 + 1;
  localparam int LIMIT = RUN + 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic          wr_enable;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] wdata;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [33:0] sb_q [$];
  logic [33:0] exp_w;
  logic [7:0]  pr [NP];
  logic [7:0]  pg [NP];
  logic [7:0]  pb [NP];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];

  rgb_to_yuv_conversion #(
    .ADDR_RGB (A_RGB),
    .ADDR_YUV (A_YUV),
    .W        (W),
    .H        (H),
    .DW       (DW),
    .AW       (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .waddr     (waddr),
    .wdata     (wdata),
    .wr_enable (wr_enable)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_enable) begin
      wr_cnt++;
      checks++;
      if (!reset) begin
        errors++;
        $display("FAIL wr_in_reset addr=%0h", waddr);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write addr=%0h data=%0h required none",
                 waddr, wdata);
      end else begin
        exp_w = sb_q.pop_front();
        if ({waddr, wdata} !== exp_w) begin
          errors++;
          $display("FAIL write addr=%0h data=%0h required addr=%0h data=%0h",
                   waddr, wdata, exp_w[33:16], exp_w[15:0]);
        end
      end
    end
  end

  function automatic int fdiv256(input int x);
    int q;
    q = x / 256;
    if ((x < 0) && (q * 256 != x)) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] clip(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic logic [7:0] my(input int r, input int g, input int b);
    return clip(fdiv256(66*r + 129*g + 25*b + 128) + 16);
  endfunction

  function automatic logic [7:0] mu(input int r, input int g, input int b);
    return clip(fdiv256(-38*r - 74*g + 112*b + 128) + 128);
  endfunction

  function automatic logic [7:0] mv(input int r, input int g, input int b);
    return clip(fdiv256(112*r - 94*g - 18*b + 128) + 128);
  endfunction

  function automatic int csrc(input int a, input int b);
`ifdef RGB2YUV_AVG_EN
    return (a + b + 1) / 2;
`else
    return a + 0 * b;
`endif
  endfunction

  task automatic load_image();
    for (int k = 0; k < NP / 2; k++) begin
      mem[A_RGB + 3*k]     = {pr[2*k], pg[2*k]};
      mem[A_RGB + 3*k + 1] = {pb[2*k], pr[2*k+1]};
      mem[A_RGB + 3*k + 2] = {pg[2*k+1], pb[2*k+1]};
    end
  endtask

  task automatic fill(input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    for (int i = 0; i < NP; i++) begin
      pr[i] = r; pg[i] = g; pb[i] = b;
    end
  endtask

  task automatic rand_image();
    for (int i = 0; i < NP; i++) begin
      pr[i] = 8'($urandom_range(0, 255));
      pg[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic push_uniform(input logic [15:0] y0w, input logic [15:0] y1w,
                              input logic [15:0] uw, input logic [15:0] vw);
    for (int g = 0; g < NG; g++) begin
      sb_q.push_back({AW'(A_YUV + 2*g), y0w});
      sb_q.push_back({AW'(A_YUV + 2*g + 1), y1w});
      sb_q.push_back({AW'(U0 + g), uw});
      sb_q.push_back({AW'(V0 + g), vw});
    end
  endtask

  task automatic push_model();
    logic [7:0] yy [4];
    logic [7:0] uu [2];
    logic [7:0] vv [2];
    int i, r, gg, b;
    for (int g = 0; g < NG; g++) begin
      for (int k = 0; k < 4; k++) begin
        i = 4*g + k;
        yy[k] = my(pr[i], pg[i], pb[i]);
      end
      for (int p = 0; p < 2; p++) begin
        i  = 4*g + 2*p;
        r  = csrc(pr[i], pr[i+1]);
        gg = csrc(pg[i], pg[i+1]);
        b  = csrc(pb[i], pb[i+1]);
        uu[p] = mu(r, gg, b);
        vv[p] = mv(r, gg, b);
      end
      sb_q.push_back({AW'(A_YUV + 2*g), yy[0], yy[1]});
      sb_q.push_back({AW'(A_YUV + 2*g + 1), yy[2], yy[3]});
      sb_q.push_back({AW'(U0 + g), uu[0], uu[1]});
      sb_q.push_back({AW'(V0 + g), vv[0], vv[1]});
    end
  endtask

  // start is high for cycles 0..start_len-1 and at cycle restart_at.
  task automatic run_conv(input string name, input int start_len,
                          input int restart_at);
    int n;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < LIMIT) begin
      @(posedge clk); #1;
      n++;
      start = (n < start_len) || (n == restart_at);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || n != RUN) begin
      errors++;
      $display("FAIL %s_done_cycle got=%0d seen=%0d required=%0d",
               name, n, seen, RUN);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse done=%b required 0", name, done);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes left=%0d required 0",
               name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_done got=%b required 0", done);
    end
    checks++;
    if (wr_enable !== 1'b0) begin
      errors++; $display("FAIL rst_wr_enable got=%b required 0", wr_enable);
    end
    checks++;
    if (raddr !== '0) begin
      errors++; $display("FAIL rst_raddr got=%0h required 0", raddr);
    end
    checks++;
    if (waddr !== '0) begin
      errors++; $display("FAIL rst_waddr got=%0h required 0", waddr);
    end
    checks++;
    if (wdata !== '0) begin
      errors++; $display("FAIL rst_wdata got=%0h required 0", wdata);
    end
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_white();
    fill(8'hFF, 8'hFF, 8'hFF);
    load_image();
    push_uniform(16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
    run_conv("white", 1, 0);
  endtask

  task automatic test_black();
    fill(8'h00, 8'h00, 8'h00);
    load_image();
    push_uniform(16'h1010, 16'h1010, 16'h8080, 16'h8080);
    run_conv("black", 1, 0);
  endtask

  task automatic test_red();
    fill(8'hFF, 8'h00, 8'h00);
    load_image();
    push_uniform(16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0);
    run_conv("red", 1, 0);
  endtask

  task automatic test_red_black();
    for (int i = 0; i < NP; i++) begin
      pr[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
      pg[i] = 8'h00;
      pb[i] = 8'h00;
    end
    load_image();
`ifdef RGB2YUV_AVG_EN
    push_uniform(16'h5210, 16'h5210, 16'h6D6D, 16'hB8B8);
`else
    push_uniform(16'h5210, 16'h5210, 16'h5A5A, 16'hF0F0);
`endif
    run_conv("red_black", 1, 0);
  endtask

  task automatic test_random();
    rand_image();
    load_image();
    push_model();
    run_conv("random", 1, 0);
  endtask

  task automatic test_back_to_back();
    rand_image();
    load_image();
    push_model();
    run_conv("b2b_first", 1, 0);
    push_model();
    run_conv("b2b_second", 1, 0);
  endtask

  task automatic test_start_ignored();
    int d0;
    d0 = done_cnt;
    rand_image();
    load_image();
    push_model();
    run_conv("start_held", 3, 5);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL start_held_dones got=%0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_abort();
    int d0, w0;
    rand_image();
    load_image();
    d0 = done_cnt;
    w0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (wr_enable !== 1'b0 || done !== 1'b0 || waddr !== '0) begin
      errors++;
      $display("FAIL abort_outputs wr=%b done=%b waddr=%0h required 0 0 0",
               wr_enable, done, waddr);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL abort_writes got=%0d required 0", wr_cnt - w0);
    end
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_done got=%0d required 0", done_cnt - d0);
    end
    push_model();
    run_conv("after_abort", 1, 0);
  endtask

  initial begin
    test_reset();
    test_white();
    test_black();
    test_red();
    test_red_black();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
